flit_sink_checker: RTL and testbench

FLIT_SINK_CHECKER -- requirements
Module: flit_sink_checker

---
 rtl/flit_sink_checker_pkg.sv | 21 ++
 rtl/sink_fifo.sv | 52 +++++
 rtl/flit_sink_checker.sv | 130 +++++++++++++
 tb/tb_flit_sink_checker.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/flit_sink_checker_pkg.sv
// Shared constants for the flit sink checker: default flit geometry, field
// positions inside a flit and the checker FSM encoding.
package flit_sink_checker_pkg;

  localparam int HDR_SZ    = 4;
  localparam int PL_SZ     = 8;
  localparam int ADDR_SZ   = 4;
  localparam int NUM_NODES = 2;

  // Flit layout {src, seq, dst}, dst in the LSBs.
  localparam int FLIT_W  = HDR_SZ + PL_SZ + ADDR_SZ;
  localparam int DST_LSB = 0;
  localparam int SEQ_LSB = ADDR_SZ;
  localparam int SRC_LSB = ADDR_SZ + PL_SZ;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } chk_state_e;

endpackage

// File: rtl/sink_fifo.sv
// Synchronous FIFO buffering flits between the NI sink port and the checker.
// DEPTH must be a power of two so the pointers wrap naturally.
module sink_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           wdata_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           rdata_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // NOTE: storage has no reset; pointers and count alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      if (do_push && !do_pop)      count_q <= count_q + CNT_W'(1);
      else if (do_pop && !do_push) count_q <= count_q - CNT_W'(1);
    end
  end

endmodule

// File: rtl/flit_sink_checker.sv
// Flit sink checker: buffers incoming flits, then checks destination and
// per-source sequence order as they drain, keeping saturating statistics.
module flit_sink_checker #(
  parameter int HDR_SZ      = flit_sink_checker_pkg::HDR_SZ,
  parameter int PL_SZ       = flit_sink_checker_pkg::PL_SZ,
  parameter int ADDR_SZ     = flit_sink_checker_pkg::ADDR_SZ,
  parameter int NUM_NODES   = flit_sink_checker_pkg::NUM_NODES,
  parameter int DEPTH       = 4,
  parameter bit STOP_ON_ERR = 1'b0
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [ADDR_SZ-1:0]              id,
  input  logic [HDR_SZ+PL_SZ+ADDR_SZ-1:0] item_in,
  input  logic                            valid,
  output logic                            busy,
  input  logic                            drain_en,
  input  logic                            clr,
  output logic [19:0]                     flit_count,
  output logic [15:0]                     seq_err_count,
  output logic [15:0]                     misroute_count,
  output logic                            err_flag,
  output logic [HDR_SZ-1:0]               last_err_src,
  output logic                            halted
);

  import flit_sink_checker_pkg::*;

  localparam int W     = HDR_SZ + PL_SZ + ADDR_SZ;
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int IDX_W = (NUM_NODES > 1) ? $clog2(NUM_NODES) : 1;
  localparam logic [HDR_SZ:0] NODES = (HDR_SZ+1)'(NUM_NODES);

  logic             fifo_full, fifo_empty, push, pop;
  logic [W-1:0]     head;
  logic [CNT_W-1:0] fifo_count;

  logic [HDR_SZ-1:0]  src;
  logic [PL_SZ-1:0]   seq;
  logic [ADDR_SZ-1:0] dst;
  logic [IDX_W-1:0]   src_idx;
  logic               src_ok, misroute, seq_ok, chk_err;

  chk_state_e state_q, state_d;

  logic [19:0]        flit_cnt_q;
  logic [15:0]        seq_err_q, mis_cnt_q;
  logic               err_q;
  logic [HDR_SZ-1:0]  last_src_q;
  logic [PL_SZ-1:0]   exp_q [NUM_NODES];

  sink_fifo #(.WIDTH(W), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (reset),
    .push_i  (push),
    .wdata_i (item_in),
    .pop_i   (pop),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign busy   = (fifo_count == CNT_W'(DEPTH));
  assign push   = valid && !fifo_full;
  assign halted = (state_q == ST_HALT);
  // A clr cycle never pops, so the head flit survives to be checked afterwards.
  assign pop    = drain_en && !fifo_empty && !halted && !clr;

  assign dst      = head[ADDR_SZ-1:0];
  assign seq      = head[ADDR_SZ +: PL_SZ];
  assign src      = head[W-1 -: HDR_SZ];
  assign src_idx  = src[IDX_W-1:0];
  assign src_ok   = ({1'b0, src} < NODES);
  assign misroute = (dst != id);
  assign seq_ok   = src_ok && (seq == exp_q[src_idx]);
  assign chk_err  = pop && (misroute || !seq_ok);

  // NOTE: assign every always_comb output a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    if (clr)                                       state_d = ST_RUN;
    else if (STOP_ON_ERR && chk_err && !halted)    state_d = ST_HALT;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_RUN;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      flit_cnt_q <= '0;
      seq_err_q  <= '0;
      mis_cnt_q  <= '0;
      err_q      <= 1'b0;
      last_src_q <= '0;
      for (int i = 0; i < NUM_NODES; i++) exp_q[i] <= '0;
    end else if (clr) begin
      flit_cnt_q <= '0;
      seq_err_q  <= '0;
      mis_cnt_q  <= '0;
      err_q      <= 1'b0;
      last_src_q <= '0;
      for (int i = 0; i < NUM_NODES; i++) exp_q[i] <= '0;
    end else if (pop) begin
      if (flit_cnt_q != '1) flit_cnt_q <= flit_cnt_q + 20'd1;
      if (misroute) begin
        if (mis_cnt_q != '1) mis_cnt_q <= mis_cnt_q + 16'd1;
        err_q      <= 1'b1;
        last_src_q <= src;
      end else begin
        if (!seq_ok) begin
          if (seq_err_q != '1) seq_err_q <= seq_err_q + 16'd1;
          err_q      <= 1'b1;
          last_src_q <= src;
        end
        // Match or resync both leave the expectation one past the seen sequence.
        if (src_ok) exp_q[src_idx] <= seq + PL_SZ'(1);
      end
    end
  end

  assign flit_count     = flit_cnt_q;
  assign seq_err_count  = seq_err_q;
  assign misroute_count = mis_cnt_q;
  assign err_flag       = err_q;
  assign last_err_src   = last_src_q;

endmodule

// File: tb/tb_flit_sink_checker.sv
// Directed bench for flit_sink_checker: one instance free-running on errors,
// one with STOP_ON_ERR=1, each driven through its own stimulus lane.
module tb_flit_sink_checker;

  logic        clk;
  logic        rst_n;
  logic [3:0]  id         [2];
  logic [15:0] item       [2];
  logic        valid      [2];
  logic        busy       [2];
  logic        drain      [2];
  logic        clr        [2];
  logic [19:0] flit_count [2];
  logic [15:0] seq_err    [2];
  logic [15:0] misroute   [2];
  logic        err_flag   [2];
  logic [3:0]  last_src   [2];
  logic        halted     [2];

  int n_checks = 0;
  int n_errors = 0;

  flit_sink_checker #(.STOP_ON_ERR(1'b0)) dut (
    .clk(clk), .reset(rst_n), .id(id[0]), .item_in(item[0]), .valid(valid[0]),
    .busy(busy[0]), .drain_en(drain[0]), .clr(clr[0]), .flit_count(flit_count[0]),
    .seq_err_count(seq_err[0]), .misroute_count(misroute[0]), .err_flag(err_flag[0]),
    .last_err_src(last_src[0]), .halted(halted[0])
  );

  flit_sink_checker #(.STOP_ON_ERR(1'b1)) dut_h (
    .clk(clk), .reset(rst_n), .id(id[1]), .item_in(item[1]), .valid(valid[1]),
    .busy(busy[1]), .drain_en(drain[1]), .clr(clr[1]), .flit_count(flit_count[1]),
    .seq_err_count(seq_err[1]), .misroute_count(misroute[1]), .err_flag(err_flag[1]),
    .last_err_src(last_src[1]), .halted(halted[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Offer one flit on lane h and hold it until the edge that accepts it.
  task automatic send(input int h, input logic [3:0] src, input logic [7:0] seq,
                      input logic [3:0] dst);
    int guard = 0;
    item[h]  = {src, seq, dst};
    valid[h] = 1'b1;
    while (busy[h] && guard < 50) begin
      tick(1);
      guard++;
    end
    if (busy[h]) check("send_timeout", 32'(busy[h]), 32'd0);
    tick(1);
    valid[h] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    for (int h = 0; h < 2; h++) begin
      id[h] = 4'd1; item[h] = '0; valid[h] = 1'b0; drain[h] = 1'b0; clr[h] = 1'b0;
    end
    tick(2);
    check("rst_busy",     32'(busy[0]),       32'd0);
    check("rst_flits",    32'(flit_count[0]), 32'd0);
    check("rst_seq_err",  32'(seq_err[0]),    32'd0);
    check("rst_misroute", 32'(misroute[0]),   32'd0);
    check("rst_err_flag", 32'(err_flag[0]),   32'd0);
    check("rst_halted",   32'(halted[1]),     32'd0);
    rst_n = 1'b1;
    tick(1);

    // In-order traffic from source 0.
    drain[0] = 1'b1;
    for (int i = 0; i < 10; i++) send(0, 4'd0, 8'(i), 4'd1);
    tick(3);
    check("inorder_flits",   32'(flit_count[0]), 32'd10);
    check("inorder_seq_err", 32'(seq_err[0]),    32'd0);
    check("inorder_err",     32'(err_flag[0]),   32'd0);

    // Back-pressure: four fill the FIFO, the fifth is held.
    drain[0] = 1'b0;
    for (int i = 0; i < 4; i++) send(0, 4'd0, 8'(10 + i), 4'd1);
    check("bp_busy_after_4", 32'(busy[0]), 32'd1);
    item[0]  = {4'd0, 8'd14, 4'd1};
    valid[0] = 1'b1;
    tick(3);
    check("bp_held_busy", 32'(busy[0]),       32'd1);
    check("bp_no_pop",    32'(flit_count[0]), 32'd10);
    drain[0] = 1'b1;
    send(0, 4'd0, 8'd14, 4'd1);
    tick(4);
    check("bp_flits",   32'(flit_count[0]), 32'd15);
    check("bp_seq_err", 32'(seq_err[0]),    32'd0);
    check("bp_busy",    32'(busy[0]),       32'd0);

    // Sequence gap on source 1, then resync.
    send(0, 4'd1, 8'd0, 4'd1);
    send(0, 4'd1, 8'd1, 4'd1);
    send(0, 4'd1, 8'd3, 4'd1);
    send(0, 4'd1, 8'd4, 4'd1);
    tick(3);
    check("gap_seq_err",  32'(seq_err[0]),    32'd1);
    check("gap_last_src", 32'(last_src[0]),   32'd1);
    check("gap_err_flag", 32'(err_flag[0]),   32'd1);
    check("gap_flits",    32'(flit_count[0]), 32'd19);

    // Misroute leaves the source expectation untouched.
    id[0] = 4'd0;
    send(0, 4'd0, 8'd99, 4'd2);
    tick(3);
    check("mis_count",    32'(misroute[0]), 32'd1);
    check("mis_last_src", 32'(last_src[0]), 32'd0);
    check("mis_seq_err",  32'(seq_err[0]),  32'd1);
    send(0, 4'd0, 8'd15, 4'd0);
    tick(3);
    check("mis_exp_kept", 32'(seq_err[0]), 32'd1);

    // Prime source 1 at 254 (one resync error), then wrap through 255 -> 0.
    send(0, 4'd1, 8'd254, 4'd0);
    send(0, 4'd1, 8'd255, 4'd0);
    send(0, 4'd1, 8'd0,   4'd0);
    tick(3);
    check("wrap_seq_err", 32'(seq_err[0]), 32'd2);

    // Untracked source counts as an error and must not disturb source 1.
    send(0, 4'd3, 8'd7, 4'd0);
    tick(3);
    check("oor_seq_err",  32'(seq_err[0]),  32'd3);
    check("oor_last_src", 32'(last_src[0]), 32'd3);
    send(0, 4'd1, 8'd1, 4'd0);
    tick(3);
    check("oor_exp_kept", 32'(seq_err[0]),    32'd3);
    check("oor_flits",    32'(flit_count[0]), 32'd26);

    // Synchronous clear.
    clr[0] = 1'b1;
    tick(1);
    clr[0] = 1'b0;
    check("clr_flits",    32'(flit_count[0]), 32'd0);
    check("clr_seq_err",  32'(seq_err[0]),    32'd0);
    check("clr_misroute", 32'(misroute[0]),   32'd0);
    check("clr_err_flag", 32'(err_flag[0]),   32'd0);
    check("clr_last_src", 32'(last_src[0]),   32'd0);
    send(0, 4'd1, 8'd0, 4'd0);
    tick(3);
    check("clr_exp_zero",  32'(seq_err[0]),    32'd0);
    check("clr_flits_one", 32'(flit_count[0]), 32'd1);

    // Asynchronous reset with three flits queued.
    drain[0] = 1'b0;
    for (int i = 1; i <= 3; i++) send(0, 4'd0, 8'(i), 4'd0);
    rst_n = 1'b0;
    #2;
    check("mrst_busy",  32'(busy[0]),       32'd0);
    check("mrst_flits", 32'(flit_count[0]), 32'd0);
    @(posedge clk);
    #1;
    rst_n    = 1'b1;
    drain[0] = 1'b1;
    tick(3);
    check("mrst_fifo_empty", 32'(flit_count[0]), 32'd0);
    send(0, 4'd0, 8'd0, 4'd0);
    tick(3);
    check("mrst_first_flit", 32'(flit_count[0]), 32'd1);
    check("mrst_seq_err",    32'(seq_err[0]),    32'd0);

    // STOP_ON_ERR instance: halt, fill, clear, then drain against exp=0.
    drain[1] = 1'b1;
    send(1, 4'd0, 8'd0, 4'd1);
    send(1, 4'd0, 8'd5, 4'd1);
    tick(3);
    check("halt_halted",  32'(halted[1]),     32'd1);
    check("halt_seq_err", 32'(seq_err[1]),    32'd1);
    check("halt_flits",   32'(flit_count[1]), 32'd2);
    for (int i = 0; i < 4; i++) send(1, 4'd0, 8'(i), 4'd1);
    check("halt_busy",     32'(busy[1]),       32'd1);
    check("halt_no_pop",   32'(flit_count[1]), 32'd2);
    clr[1] = 1'b1;
    tick(1);
    clr[1] = 1'b0;
    check("halt_clr_run",   32'(halted[1]),     32'd0);
    check("halt_clr_flits", 32'(flit_count[1]), 32'd0);
    tick(6);
    check("halt_drain_flits",   32'(flit_count[1]), 32'd4);
    check("halt_drain_seq_err", 32'(seq_err[1]),    32'd0);
    check("halt_drain_busy",    32'(busy[1]),       32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
